// File: rtl/cipher_arbiter_if.sv
// Requester, cipher and status signals shared by cipher_arbiter and its environment.
// The arbiter takes the slave side; the environment takes the master side.
interface cipher_arbiter_if;
    logic         req_a_in;
    logic         req_b_in;
    logic [127:0] block_a_in;
    logic [127:0] block_b_in;
    logic [127:0] key_a_in;
    logic [127:0] key_b_in;
    logic         ack_a_out;
    logic         ack_b_out;
    logic [127:0] result_a_out;
    logic [127:0] result_b_out;
    logic         valid_a_out;
    logic         valid_b_out;
    logic         cipher_start_out;
    logic [127:0] cipher_block_out;
    logic [127:0] cipher_key_out;
    logic [127:0] cipher_result_in;
    logic         cipher_valid_in;
    logic         timeout_out;
    logic         cipher_rst_out;

    modport master (
        output req_a_in, req_b_in,
        output block_a_in, block_b_in, key_a_in, key_b_in,
        input  ack_a_out, ack_b_out,
        input  result_a_out, result_b_out,
        input  valid_a_out, valid_b_out,
        input  cipher_start_out, cipher_block_out, cipher_key_out,
        output cipher_result_in, cipher_valid_in,
        input  timeout_out, cipher_rst_out
    );

    modport slave (
        input  req_a_in, req_b_in,
        input  block_a_in, block_b_in, key_a_in, key_b_in,
        output ack_a_out, ack_b_out,
        output result_a_out, result_b_out,
        output valid_a_out, valid_b_out,
        output cipher_start_out, cipher_block_out, cipher_key_out,
        input  cipher_result_in, cipher_valid_in,
        output timeout_out, cipher_rst_out
    );
endinterface

// File: rtl/cipher_arbiter.sv
// Round-robin arbiter sharing one block cipher between requesters A and B,
// with a per-job watchdog that aborts and resets the cipher on a hang.
module cipher_arbiter #(
    parameter int TIMEOUT = 255
) (
    input logic             clk_in,
    input logic             rst_in,
    cipher_arbiter_if.slave bus
);

    localparam logic [7:0] TMO = TIMEOUT[7:0];

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DELIVER
    } state_t;

    state_t       state, state_n;
    logic         owner_b, owner_b_n;
    logic         last_b, last_b_n;
    logic [7:0]   cnt, cnt_n;
    logic         grant_b;

    logic         ack_a, ack_a_n;
    logic         ack_b, ack_b_n;
    logic         start, start_n;
    logic         valid_a, valid_a_n;
    logic         valid_b, valid_b_n;
    logic         tmo, tmo_n;
    logic         crst, crst_n;
    logic [127:0] res_a, res_a_n;
    logic [127:0] res_b, res_b_n;
    logic [127:0] blk, blk_n;
    logic [127:0] key, key_n;

    // On a tie, B wins only if A took the previous grant.
    assign grant_b = bus.req_b_in & (~bus.req_a_in | ~last_b);

    always_comb begin
        state_n   = state;
        owner_b_n = owner_b;
        last_b_n  = last_b;
        cnt_n     = cnt;
        ack_a_n   = 1'b0;
        ack_b_n   = 1'b0;
        start_n   = 1'b0;
        valid_a_n = 1'b0;
        valid_b_n = 1'b0;
        tmo_n     = 1'b0;
        crst_n    = 1'b0;
        res_a_n   = res_a;
        res_b_n   = res_b;
        blk_n     = blk;
        key_n     = key;
        unique case (state)
            IDLE: begin
                if (bus.req_a_in | bus.req_b_in) begin
                    owner_b_n = grant_b;
                    last_b_n  = grant_b;
                    ack_a_n   = ~grant_b;
                    ack_b_n   = grant_b;
                    blk_n     = grant_b ? bus.block_b_in : bus.block_a_in;
                    key_n     = grant_b ? bus.key_b_in : bus.key_a_in;
                    state_n   = ISSUE;
                end
            end
            ISSUE: begin
                start_n = 1'b1;
                cnt_n   = 8'd0;
                state_n = WAIT;
            end
            WAIT: begin
                cnt_n = cnt + 8'd1;
                // A completion in the same cycle as the deadline still counts.
                if (bus.cipher_valid_in) begin
                    if (owner_b) begin
                        res_b_n   = bus.cipher_result_in;
                        valid_b_n = 1'b1;
                    end else begin
                        res_a_n   = bus.cipher_result_in;
                        valid_a_n = 1'b1;
                    end
                    state_n = DELIVER;
                end else if (cnt + 8'd1 == TMO) begin
                    tmo_n   = 1'b1;
                    crst_n  = 1'b1;
                    state_n = IDLE;
                end
            end
            DELIVER: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state   <= IDLE;
            owner_b <= 1'b0;
            last_b  <= 1'b1;
            cnt     <= 8'd0;
            ack_a   <= 1'b0;
            ack_b   <= 1'b0;
            start   <= 1'b0;
            valid_a <= 1'b0;
            valid_b <= 1'b0;
            tmo     <= 1'b0;
            crst    <= 1'b0;
            res_a   <= '0;
            res_b   <= '0;
            blk     <= '0;
            key     <= '0;
        end else begin
            state   <= state_n;
            owner_b <= owner_b_n;
            last_b  <= last_b_n;
            cnt     <= cnt_n;
            ack_a   <= ack_a_n;
            ack_b   <= ack_b_n;
            start   <= start_n;
            valid_a <= valid_a_n;
            valid_b <= valid_b_n;
            tmo     <= tmo_n;
            crst    <= crst_n;
            res_a   <= res_a_n;
            res_b   <= res_b_n;
            blk     <= blk_n;
            key     <= key_n;
        end
    end

    assign bus.ack_a_out        = ack_a;
    assign bus.ack_b_out        = ack_b;
    assign bus.result_a_out     = res_a;
    assign bus.result_b_out     = res_b;
    assign bus.valid_a_out      = valid_a;
    assign bus.valid_b_out      = valid_b;
    assign bus.cipher_start_out = start;
    assign bus.cipher_block_out = blk;
    assign bus.cipher_key_out   = key;
    assign bus.timeout_out      = tmo;
    assign bus.cipher_rst_out   = crst;

endmodule
